i2s_tx_multich_core: RTL and testbench

Parametrised multi-channel I2S transmitter core. It accepts AXI-Stream audio samples tagged with a channel ID and buffers them in an internal FIFO. It generates SCLK and LRCLK from aud_mclk using a runtime divider, and serialises NUM_CH slots per frame in I2S format with a one-bit delay. It sits between the AXI-Stream audio input and the I2S pins, and generalises the fixed 24-bit stereo transmitter to configurable width, depth and channel count, with underflow and misalignment reporting.

---
 rtl/i2s_tx_multich_core.sv | 233 +++++++++++++++++++++++
 tb/tb_i2s_tx_multich_core.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_multich_core.sv
// Multi-channel I2S transmitter: AXI-Stream sample FIFO tagged by channel ID,
// runtime SCLK divider, and NUM_CH 32-bit slots per frame with a one-bit delay.
module i2s_tx_multich_core #(
    parameter int unsigned AUD_WIDTH       = 24,
    parameter int unsigned AXIS_DATA_WIDTH = 32,
    parameter int unsigned TID_WIDTH       = 3,
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned FIFO_DEPTH      = 128,
    parameter int unsigned DIV_WIDTH       = 8
) (
    input  logic                         aud_mclk,
    input  logic                         aud_mrst,
    input  logic                         enable,
    input  logic [DIV_WIDTH-1:0]         sclk_div,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_aud_tdata,
    input  logic [TID_WIDTH-1:0]         s_axis_aud_tid,
    input  logic                         s_axis_aud_tvalid,
    output logic                         s_axis_aud_tready,
    output logic                         sclk_out,
    output logic                         lrclk_out,
    output logic                         sdata_out,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         underflow,
    output logic                         misalign
);

    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W      = PTR_W + 1;
    localparam int unsigned ENT_W      = TID_WIDTH + AUD_WIDTH;
    localparam int unsigned FRAME_BITS = NUM_CH * 32;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

    localparam logic [TID_WIDTH:0] NUM_CH_T  = (TID_WIDTH+1)'(NUM_CH);
    localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0]   HALF_BIT  = BIT_W'(NUM_CH * 16);
    localparam logic [LVL_W-1:0]   FULL_LVL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    // ------------------------------------------------------------------
    // Sample FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [ENT_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_d;
    logic                 push_hs;
    logic                 push_wr;
    logic                 pop;
    logic                 fifo_empty;
    logic [ENT_W-1:0]     head;
    logic [TID_WIDTH-1:0] head_tid;
    logic [AUD_WIDTH-1:0] head_aud;
    logic                 unused_tdata;

    assign unused_tdata = ^s_axis_aud_tdata;

    assign push_hs    = s_axis_aud_tvalid && s_axis_aud_tready;
    // Out-of-range channel IDs complete the handshake but never occupy space.
    assign push_wr    = push_hs && ({1'b0, s_axis_aud_tid} < NUM_CH_T);
    assign fifo_empty = (fifo_level == '0);
    assign head       = mem[rd_ptr];
    assign head_tid   = head[ENT_W-1 -: TID_WIDTH];
    assign head_aud   = head[AUD_WIDTH-1:0];

    always_comb begin
        level_d = fifo_level;
        if (push_wr && !pop) begin
            level_d = fifo_level + LVL_W'(1);
        end else if (!push_wr && pop) begin
            level_d = fifo_level - LVL_W'(1);
        end
    end

    always_ff @(posedge aud_mclk) begin
        if (push_wr) begin
            mem[wr_ptr] <= {s_axis_aud_tid, s_axis_aud_tdata[AUD_WIDTH+3:4]};
        end
    end

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fifo_level        <= '0;
            s_axis_aud_tready <= 1'b0;
        end else begin
            if (push_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level        <= level_d;
            s_axis_aud_tready <= (level_d != FULL_LVL);
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t               state_q;
    state_t               state_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_q_d;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_cnt_d;
    logic [BIT_W-1:0]     bitcnt;
    logic [BIT_W-1:0]     bitcnt_d;
    logic [BIT_W-1:0]     bit_nxt;
    logic [AUD_WIDTH-1:0] shreg;
    logic [AUD_WIDTH-1:0] shreg_d;
    logic                 sclk_d;
    logic                 lrclk_d;
    logic                 sdata_d;
    logic                 underflow_d;
    logic                 misalign_d;
    logic                 div_tc;
    logic                 load;
    logic [TID_WIDTH-1:0] load_slot;

    assign div_tc  = (div_cnt == (div_q - DIV_WIDTH'(1)));
    assign bit_nxt = (bitcnt == LAST_BIT) ? '0 : (bitcnt + BIT_W'(1));

    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            state_q   <= ST_IDLE;
            div_q     <= DIV_WIDTH'(1);
            div_cnt   <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            sclk_out  <= 1'b0;
            lrclk_out <= 1'b0;
            sdata_out <= 1'b0;
            underflow <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_q_d;
            div_cnt   <= div_cnt_d;
            bitcnt    <= bitcnt_d;
            shreg     <= shreg_d;
            sclk_out  <= sclk_d;
            lrclk_out <= lrclk_d;
            sdata_out <= sdata_d;
            underflow <= underflow_d;
            misalign  <= misalign_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_q_d     = div_q;
        div_cnt_d   = div_cnt;
        bitcnt_d    = bitcnt;
        shreg_d     = shreg;
        sclk_d      = sclk_out;
        lrclk_d     = lrclk_out;
        sdata_d     = sdata_out;
        underflow_d = 1'b0;
        misalign_d  = 1'b0;
        load        = 1'b0;
        load_slot   = '0;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sclk_d    = 1'b0;
                lrclk_d   = 1'b0;
                sdata_d   = 1'b0;
                div_cnt_d = '0;
                bitcnt_d  = '0;
                if (enable) begin
                    div_q_d = (sclk_div == '0) ? DIV_WIDTH'(1) : sclk_div;
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_DRAIN: begin
                if ((state_q == ST_RUN) && !enable) begin
                    state_d = ST_DRAIN;
                end
                if (div_tc) begin
                    div_cnt_d = '0;
                    sclk_d    = !sclk_out;
                    // Falling SCLK edge: advance the bit and present the next data bit.
                    if (sclk_out) begin
                        bitcnt_d = bit_nxt;
                        lrclk_d  = (bit_nxt >= HALF_BIT);
                        if (bit_nxt[4:0] == 5'd0) begin
                            sdata_d = 1'b0;
                            if ((state_q == ST_DRAIN) && (bit_nxt == '0)) begin
                                state_d = ST_IDLE;
                            end else begin
                                load      = 1'b1;
                                load_slot = TID_WIDTH'(bit_nxt >> 5);
                            end
                        end else begin
                            sdata_d = shreg[AUD_WIDTH-1];
                            shreg_d = {shreg[AUD_WIDTH-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt + DIV_WIDTH'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Slot load: the head is consumed only when it belongs to this slot.
        if (load) begin
            if (fifo_empty) begin
                underflow_d = 1'b1;
                shreg_d     = '0;
            end else if (head_tid == load_slot) begin
                pop     = 1'b1;
                shreg_d = head_aud;
            end else begin
                misalign_d = 1'b1;
                shreg_d    = '0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_multich_core.sv
// Directed self-checking bench for i2s_tx_multich_core (stereo, 24-bit, depth 128).
module tb_i2s_tx_multich_core;

    logic        aud_mclk = 1'b0;
    logic        aud_mrst;
    logic        enable;
    logic [7:0]  sclk_div;
    logic [31:0] s_axis_aud_tdata;
    logic [2:0]  s_axis_aud_tid;
    logic        s_axis_aud_tvalid;
    logic        s_axis_aud_tready;
    logic        sclk_out;
    logic        lrclk_out;
    logic        sdata_out;
    logic [7:0]  fifo_level;
    logic        underflow;
    logic        misalign;

    always #5 aud_mclk = ~aud_mclk;

    i2s_tx_multich_core #(
        .AUD_WIDTH      (24),
        .AXIS_DATA_WIDTH(32),
        .TID_WIDTH      (3),
        .NUM_CH         (2),
        .FIFO_DEPTH     (128),
        .DIV_WIDTH      (8)
    ) dut (
        .aud_mclk         (aud_mclk),
        .aud_mrst         (aud_mrst),
        .enable           (enable),
        .sclk_div         (sclk_div),
        .s_axis_aud_tdata (s_axis_aud_tdata),
        .s_axis_aud_tid   (s_axis_aud_tid),
        .s_axis_aud_tvalid(s_axis_aud_tvalid),
        .s_axis_aud_tready(s_axis_aud_tready),
        .sclk_out         (sclk_out),
        .lrclk_out        (lrclk_out),
        .sdata_out        (sdata_out),
        .fifo_level       (fifo_level),
        .underflow        (underflow),
        .misalign         (misalign)
    );

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] LR_FRAME = 64'hFFFF_FFFF_0000_0000;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame bits indexed by bitcnt: delay bit, 24 data bits MSB first, 7 zeros.
    function automatic logic [63:0] frame_bits(input logic [23:0] s0, input logic [23:0] s1);
        logic [63:0] f;
        f = '0;
        for (int b = 1; b <= 24; b++) begin
            f[b]      = s0[24-b];
            f[32 + b] = s1[24-b];
        end
        return f;
    endfunction

    task automatic push(input logic [2:0] tid, input logic [23:0] aud);
        s_axis_aud_tid    = tid;
        s_axis_aud_tdata  = {4'hF, aud, 4'hA};
        s_axis_aud_tvalid = 1'b1;
        @(posedge aud_mclk); #1;
        s_axis_aud_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        enable   = 1'b0;
        aud_mrst = 1'b1;
        #2;
        aud_mrst = 1'b0;
        @(posedge aud_mclk); #1;
    endtask

    // Records sdata/lrclk at each SCLK rising edge, as an I2S receiver would.
    task automatic capture(input string tag, input int n, input int budget,
                           output logic [127:0] sd, output logic [127:0] lr,
                           output int t_first, output int t_last,
                           output int n_uf, output int n_ma);
        logic prev;
        int   cyc;
        int   got;
        sd = '0; lr = '0; t_first = -1; t_last = -1; n_uf = 0; n_ma = 0;
        got = 0; cyc = 0; prev = sclk_out;
        while (got < n && cyc < budget) begin
            @(posedge aud_mclk); #1;
            cyc++;
            if (underflow) n_uf++;
            if (misalign)  n_ma++;
            if (sclk_out && !prev) begin
                sd[got] = sdata_out;
                lr[got] = lrclk_out;
                if (got == 0) t_first = cyc;
                t_last = cyc;
                got++;
            end
            prev = sclk_out;
        end
        check({tag, "_edges"}, 128'(got), 128'(n));
    endtask

    logic [127:0] sd, lr;
    logic [63:0]  acc_sd, acc_lr;
    int           tf, tl, nuf, nma, quiet;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        aud_mrst          = 1'b1;
        enable            = 1'b0;
        sclk_div          = 8'd1;
        s_axis_aud_tdata  = '0;
        s_axis_aud_tid    = '0;
        s_axis_aud_tvalid = 1'b0;

        // Reset state
        @(posedge aud_mclk); #1;
        check("rst_tready", 128'(s_axis_aud_tready), 128'(0));
        check("rst_outs", 128'({sclk_out, lrclk_out, sdata_out, underflow, misalign}), 128'(0));
        check("rst_level", 128'(fifo_level), 128'(0));
        aud_mrst = 1'b0;
        @(posedge aud_mclk); #1;
        check("rst_tready_rise", 128'(s_axis_aud_tready), 128'(1));

        // Stereo basic
        push(3'd0, 24'hABCDE1);
        push(3'd1, 24'h123456);
        check("stereo_prefill_level", 128'(fifo_level), 128'(2));
        sclk_div = 8'd1;
        enable   = 1'b1;
        capture("stereo", 64, 300, sd, lr, tf, tl, nuf, nma);
        check("stereo_sdata", sd, 128'(frame_bits(24'hABCDE1, 24'h123456)));
        check("stereo_lrclk", lr, 128'(LR_FRAME));
        check("stereo_first_rise", 128'(tf), 128'(2));
        check("stereo_frame_len", 128'(tl - tf), 128'(126));
        check("stereo_no_pulses", 128'(nuf + nma), 128'(0));
        check("stereo_level_after", 128'(fifo_level), 128'(0));

        // Underflow
        do_reset();
        enable = 1'b1;
        capture("uflow", 128, 400, sd, lr, tf, tl, nuf, nma);
        check("uflow_sdata", sd, 128'(0));
        check("uflow_lrclk", lr, {LR_FRAME, LR_FRAME});
        check("uflow_pulses", 128'(nuf), 128'(4));
        check("uflow_no_misalign", 128'(nma), 128'(0));
        check("uflow_level", 128'(fifo_level), 128'(0));

        // Misalignment and automatic realignment
        do_reset();
        push(3'd1, 24'hC00003);
        push(3'd0, 24'h5A5A5A);
        push(3'd1, 24'h0F00F1);
        enable = 1'b1;
        capture("malign", 128, 400, sd, lr, tf, tl, nuf, nma);
        check("malign_frame0", 128'(sd[63:0]), 128'(frame_bits(24'h000000, 24'hC00003)));
        check("malign_frame1", 128'(sd[127:64]), 128'(frame_bits(24'h5A5A5A, 24'h0F00F1)));
        check("malign_pulses", 128'(nma), 128'(1));
        check("malign_no_uflow", 128'(nuf), 128'(0));
        check("malign_level", 128'(fifo_level), 128'(0));

        // Full FIFO with enable low
        do_reset();
        s_axis_aud_tvalid = 1'b1;
        for (int i = 1; i <= 130; i++) begin
            s_axis_aud_tid   = 3'(i % 2);
            s_axis_aud_tdata = 32'(i) << 4;
            @(posedge aud_mclk); #1;
            if (i == 127) begin
                check("full_level_127", 128'(fifo_level), 128'(127));
                check("full_tready_127", 128'(s_axis_aud_tready), 128'(1));
            end
            if (i == 128) begin
                check("full_level_128", 128'(fifo_level), 128'(128));
                check("full_tready_128", 128'(s_axis_aud_tready), 128'(0));
            end
        end
        s_axis_aud_tvalid = 1'b0;
        check("full_level_end", 128'(fifo_level), 128'(128));
        check("full_tready_end", 128'(s_axis_aud_tready), 128'(0));

        // Out-of-range channel ID is accepted and dropped
        do_reset();
        push(3'd0, 24'h13579B);
        check("drop_tready", 128'(s_axis_aud_tready), 128'(1));
        push(3'd7, 24'hEEEEEE);
        check("drop_level", 128'(fifo_level), 128'(1));
        push(3'd1, 24'h2468AC);
        check("drop_level2", 128'(fifo_level), 128'(2));
        enable = 1'b1;
        capture("drop", 64, 300, sd, lr, tf, tl, nuf, nma);
        check("drop_sdata", sd, 128'(frame_bits(24'h13579B, 24'h2468AC)));

        // Divider 3, ignored divider change, drain from bit 10
        do_reset();
        push(3'd0, 24'h800001);
        push(3'd1, 24'h7FFFFE);
        push(3'd0, 24'h333333);
        sclk_div = 8'd3;
        enable   = 1'b1;
        capture("div3a", 5, 100, sd, lr, tf, tl, nuf, nma);
        check("div3_first_rise", 128'(tf), 128'(4));
        check("div3_period", 128'(tl - tf), 128'(24));
        acc_sd[4:0] = sd[4:0];
        acc_lr[4:0] = lr[4:0];
        sclk_div = 8'd1;
        capture("div3b", 6, 100, sd, lr, tf, tl, nuf, nma);
        check("div3_change_ignored", 128'(tl - tf), 128'(30));
        acc_sd[10:5] = sd[5:0];
        acc_lr[10:5] = lr[5:0];
        enable = 1'b0;
        capture("drain", 53, 800, sd, lr, tf, tl, nuf, nma);
        acc_sd[63:11] = sd[52:0];
        acc_lr[63:11] = lr[52:0];
        check("drain_sdata", 128'(acc_sd), 128'(frame_bits(24'h800001, 24'h7FFFFE)));
        check("drain_lrclk", 128'(acc_lr), 128'(LR_FRAME));
        repeat (10) begin
            @(posedge aud_mclk); #1;
        end
        check("drain_outs_zero", 128'({sclk_out, lrclk_out, sdata_out}), 128'(0));
        check("drain_no_wrap_load", 128'(fifo_level), 128'(1));
        quiet = 0;
        repeat (30) begin
            @(posedge aud_mclk); #1;
            if (sclk_out || lrclk_out || sdata_out) quiet++;
        end
        check("drain_stays_idle", 128'(quiet), 128'(0));

        // Reset mid-frame at bit 40
        do_reset();
        push(3'd0, 24'h00000F);
        push(3'd1, 24'hFFFFFF);
        push(3'd0, 24'h444444);
        sclk_div = 8'd1;
        enable   = 1'b1;
        capture("midrst", 41, 200, sd, lr, tf, tl, nuf, nma);
        check("midrst_pre_level", 128'(fifo_level), 128'(1));
        check("midrst_pre_outs", 128'({lrclk_out, sdata_out}), 128'(3));
        aud_mrst = 1'b1;
        #1;
        check("midrst_outs_zero", 128'({sclk_out, lrclk_out, sdata_out, underflow, misalign}), 128'(0));
        check("midrst_level_zero", 128'(fifo_level), 128'(0));
        check("midrst_tready_zero", 128'(s_axis_aud_tready), 128'(0));
        #1;
        aud_mrst = 1'b0;
        capture("restart", 64, 300, sd, lr, tf, tl, nuf, nma);
        check("restart_first_rise", 128'(tf), 128'(2));
        check("restart_lrclk", lr, 128'(LR_FRAME));
        check("restart_sdata", sd, 128'(0));
        check("restart_uflow", 128'(nuf), 128'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
